// File: rtl/stim_capture_seq.sv
// stim_capture_seq -- drives a fixed table of six (X,N) stimulus vectors into
// an external logic circuit, waits for the response to settle, captures the
// response F, and folds each capture into an 8-bit MISR signature.
//
// Ports
//   clk        rising-edge clock for all state
//   reset      asynchronous, active-high reset
//   start      one-cycle request to run the sequence (honoured only in IDLE)
//   f_in[3:0]  response from the circuit under test (sampled only in CAPTURE)
//   x_out[3:0] registered X operand to the circuit
//   n_out[3:0] registered N operand to the circuit
//   busy       high from the accepting start edge until the run ends
//   cap_valid  one-cycle strobe, high in the cycle after a capture
//   cap_data   f_in value taken at the most recent capture
//   vec_idx    index of the vector currently applied (0..5)
//   misr[7:0]  running response signature
//   done       one-cycle strobe in the cycle after DONE
//   pass       final misr == EXP_SIG; held until the next accepted start
//
// Timing: each vector is DRIVE (1) + SETTLE (SETTLE_CYCLES) + CAPTURE (1)
// cycles. Six vectors plus DONE give 6*(SETTLE_CYCLES+2)+1 cycles, starting
// with the first DRIVE cycle. cap_valid, done and pass are registered, so each
// one shows up in the cycle after the state that produces it.

module stim_capture_seq #(
  parameter int unsigned SETTLE_CYCLES = 2,   // legal range 1..15
  parameter logic [7:0]  EXP_SIG       = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] f_in,
  output logic [3:0] x_out,
  output logic [3:0] n_out,
  output logic       busy,
  output logic       cap_valid,
  output logic [3:0] cap_data,
  output logic [2:0] vec_idx,
  output logic [7:0] misr,
  output logic       done,
  output logic       pass
);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CAPTURE,
    DONE
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
  localparam logic [2:0] LAST_VEC    = 3'd5;

  state_t     state;
  state_t     state_next;
  logic [3:0] settle_cnt;
  logic [7:0] misr_next;
  logic       fb;

  // Fixed stimulus table, returned as {X, N}.
  function automatic logic [7:0] vec_table(input logic [2:0] idx);
    logic [7:0] v;
    case (idx)
      3'd0:    v = {4'b1111, 4'b0111};
      3'd1:    v = {4'b1000, 4'b0111};
      3'd2:    v = {4'b1111, 4'b0101};
      3'd3:    v = {4'b1110, 4'b0001};
      3'd4:    v = {4'b0010, 4'b0111};
      3'd5:    v = {4'b0111, 4'b0001};
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // Signature step: shift in the tap feedback, then fold the response into
  // the low nibble.
  always_comb begin
    fb        = misr[7] ^ misr[5] ^ misr[4] ^ misr[3];
    misr_next = {misr[6:0], fb} ^ {4'b0000, f_in};
  end

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples pre-edge values; blocking here would make the result
  // depend on statement order and diverge from the synthesised netlist.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next is assigned a default before the case so that no path
  // leaves it unassigned; a missing default would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = DRIVE;
      DRIVE:   state_next = SETTLE;
      SETTLE:  if (settle_cnt == 4'd1) state_next = CAPTURE;
      CAPTURE: state_next = (vec_idx == LAST_VEC) ? DONE : DRIVE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs. start is looked at only in IDLE, so a
  // start pulse during a run (including DONE) is dropped rather than queued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_out      <= 4'd0;
      n_out      <= 4'd0;
      busy       <= 1'b0;
      cap_valid  <= 1'b0;
      cap_data   <= 4'd0;
      vec_idx    <= 3'd0;
      misr       <= 8'd0;
      done       <= 1'b0;
      pass       <= 1'b0;
      settle_cnt <= 4'd0;
    end else begin
      cap_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            vec_idx <= 3'd0;
            misr    <= 8'd0;
            pass    <= 1'b0;
          end
        end
        DRIVE: begin
          {x_out, n_out} <= vec_table(vec_idx);
          settle_cnt     <= SETTLE_LOAD;
        end
        SETTLE: begin
          settle_cnt <= settle_cnt - 4'd1;
        end
        CAPTURE: begin
          cap_data  <= f_in;
          cap_valid <= 1'b1;
          misr      <= misr_next;
          if (vec_idx != LAST_VEC) begin
            vec_idx <= vec_idx + 3'd1;
          end
        end
        DONE: begin
          done <= 1'b1;
          pass <= (misr == EXP_SIG);
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/stim_capture_seq.md
STIM_CAPTURE_SEQ -- requirements
Module: stim_capture_seq

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, SHALL set the wait cycles (range 1..15) between driving a vector and sampling the response.
REQ-002 Parameter EXP_SIG, default 8'h00, SHALL be the expected final signature used for the pass flag.
REQ-003 clk  input  1  single clock; all state updates SHALL occur on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to run the vector sequence.
REQ-006 f_in  input  4  response F from the logic_circuit under test.
REQ-007 x_out  output  4  registered X operand driven to the logic_circuit.
REQ-008 n_out  output  4  registered N operand driven to the logic_circuit.
REQ-009 busy  output  1  high while a sequence is running.
REQ-010 cap_valid  output  1  one-cycle strobe marking a captured response.
REQ-011 cap_data  output  4  f_in value sampled at the last cap_valid.
REQ-012 vec_idx  output  3  index of the vector currently applied (0..5).
REQ-013 misr  output  8  running response signature.
REQ-014 done  output  1  one-cycle strobe at sequence end.
REQ-015 pass  output  1  high when the final misr equals EXP_SIG; holds until the next start.

Function
REQ-016 The vector table SHALL be fixed, (X,N) per index: 0:(1111,0111) 1:(1000,0111) 2:(1111,0101) 3:(1110,0001) 4:(0010,0111) 5:(0111,0001).
REQ-017 FSM states SHALL be IDLE, DRIVE, SETTLE, CAPTURE, DONE.
REQ-018 IDLE + start=1 -> DRIVE on the next edge; busy=1, vec_idx=0, misr=0, pass=0 from that edge.
REQ-019 DRIVE SHALL load x_out/n_out from table[vec_idx] and go to SETTLE.
REQ-020 SETTLE SHALL stay exactly SETTLE_CYCLES cycles (down-counter), then go to CAPTURE.
REQ-021 CAPTURE SHALL sample f_in into cap_data, pulse cap_valid for that cycle, and update misr.
REQ-022 MISR update: fb = misr[7]^misr[5]^misr[4]^misr[3]; misr_next = {misr[6:0],fb} ^ {4'b0000,f_in}.
REQ-023 From CAPTURE: vec_idx<5 -> increment vec_idx, go to DRIVE; vec_idx==5 -> go to DONE.
REQ-024 DONE SHALL pulse done for one cycle, register pass = (misr==EXP_SIG), clear busy, return to IDLE.
REQ-025 Each vector SHALL take SETTLE_CYCLES+2 cycles; a full run SHALL take 6*(SETTLE_CYCLES+2)+1 cycles from the first DRIVE through DONE (25 with the default).
REQ-026 start SHALL be ignored in every state except IDLE; a start asserted in DONE SHALL NOT be queued.
REQ-027 x_out, n_out, cap_data, misr SHALL hold their last values in IDLE after a run.
REQ-028 f_in SHALL be sampled only in CAPTURE; changes at other times SHALL have no effect.

Reset
REQ-029 reset=1 SHALL immediately (asynchronously) force state=IDLE, x_out=0, n_out=0, vec_idx=0, misr=0, cap_data=0, busy=0, cap_valid=0, done=0, pass=0.
REQ-030 Reset asserted mid-run SHALL abort the run with no done pulse; after release the block SHALL wait in IDLE for a new start.
REQ-031 start asserted on the first edge after reset release SHALL be accepted normally.

Verification
REQ-032 Reset then start with f_in held at 4'b0000 -> six cap_valid pulses, vec_idx 0..5, x_out/n_out stepping through the REQ-016 table, final misr=8'h00, done pulse, pass=1 with EXP_SIG=8'h00.
REQ-033 f_in held at 4'b0001, SETTLE_CYCLES=2 -> misr after each capture 01,03,07,0F,1E,3D; done 25 cycles after the first DRIVE; pass=0 with EXP_SIG=8'h00.
REQ-034 Cycle count: with SETTLE_CYCLES=2, cap_valid pulses exactly 4 cycles apart; with SETTLE_CYCLES=1, 3 cycles apart.
REQ-035 start re-pulsed during SETTLE of vector 2 -> no restart, vec_idx continues to 3, total run length unchanged.
REQ-036 reset asserted in CAPTURE of vector 3 -> all outputs at reset values in the same cycle, no done; new start yields a full correct 6-vector run.
REQ-037 f_in toggled every cycle except in CAPTURE (held 4'b0001 there) -> final misr=8'h3D, identical to REQ-033.
